// File: rtl/pulse_pkg.sv
// Shared types and default widths for the pulse train generator and its
// companion pulse counter.
package pulse_pkg;

    localparam int CNT_WIDTH_DEF = 32;
    localparam int GAP_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } pulse_state_t;

endpackage

// File: rtl/pulse_gap_timer.sv
// Load/decrement down-counter timing the low gap between pulses.
module pulse_gap_timer
    import pulse_pkg::*;
#(
    parameter int GAP_WIDTH = GAP_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 dec_i,
    input  logic [GAP_WIDTH-1:0] load_val_i,
    output logic                 zero_o
);

    logic [GAP_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i) begin
            cnt_q <= cnt_q - GAP_WIDTH'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Emits num_i single-cycle pulses spaced by gap_i low cycles, with
// start/busy/done handshake and abort. Define PULSE_TRAIN_CONT_EN to make
// num_i=0 select continuous mode (runs until abort).
module pulse_train_gen
    import pulse_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int GAP_WIDTH = GAP_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] num_i,
    input  logic [GAP_WIDTH-1:0] gap_i,
    output logic                 pulse_o,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] sent_o
);

`ifdef PULSE_TRAIN_CONT_EN
    localparam bit CONT_EN = 1'b1;
`else
    localparam bit CONT_EN = 1'b0;
`endif

    pulse_state_t         state_q, state_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic [GAP_WIDTH-1:0] gap_q, gap_d;
    logic [CNT_WIDTH-1:0] sent_q, sent_d;
    logic                 cont_q, cont_d;
    logic [CNT_WIDTH-1:0] sent_inc;
    logic                 tmr_load, tmr_dec, tmr_zero;
    logic                 pulse_q, busy_q, done_q;

    assign sent_inc = sent_q + CNT_WIDTH'(1);

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        gap_d    = gap_q;
        sent_d   = sent_q;
        cont_d   = cont_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    num_d   = num_i;
                    gap_d   = gap_i;
                    sent_d  = '0;
                    cont_d  = CONT_EN && (num_i == '0);
                    state_d = (num_i != '0 || CONT_EN) ? PULSE : DONE;
                end
            end
            PULSE: begin
                sent_d = sent_inc;
                // Continuous mode never terminates on count, only on abort.
                if (abort || (!cont_q && sent_inc == num_q)) begin
                    state_d = DONE;
                end else if (gap_q == '0) begin
                    state_d = PULSE;
                end else begin
                    state_d  = GAP;
                    tmr_load = 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = DONE;
                end else if (tmr_zero) begin
                    state_d = PULSE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            num_q   <= '0;
            gap_q   <= '0;
            sent_q  <= '0;
            cont_q  <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            gap_q   <= gap_d;
            sent_q  <= sent_d;
            cont_q  <= cont_d;
            pulse_q <= (state_d == PULSE);
            busy_q  <= (state_d == PULSE) || (state_d == GAP);
            done_q  <= (state_d == DONE);
        end
    end

    pulse_gap_timer #(
        .GAP_WIDTH(GAP_WIDTH)
    ) u_gap_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (tmr_load),
        .dec_i     (tmr_dec),
        .load_val_i(gap_q - GAP_WIDTH'(1)),
        .zero_o    (tmr_zero)
    );

    assign pulse_o = pulse_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sent_o  = sent_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: driver predicts pulse/done events
// from train arithmetic, monitor pops and compares as outputs appear.
module tb_pulse_train_gen;

    localparam int CW  = 32;
    localparam int GW  = 16;
    localparam int INF = 32'h3fffffff;
`ifdef PULSE_TRAIN_CONT_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] num_i = '0;
    logic [GW-1:0] gap_i = '0;
    logic          pulse_o, busy, done;
    logic [CW-1:0] sent_o;

    pulse_train_gen #(.CNT_WIDTH(CW), .GAP_WIDTH(GW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_i(num_i), .gap_i(gap_i), .pulse_o(pulse_o), .busy(busy),
        .done(done), .sent_o(sent_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit is_pulse;
        int sent;
    } ev_t;

    ev_t q[$];
    int  cyc;
    int  checks;
    int  errors;
    int  pcnt;
    int  bfrom, bto;
    bit  mon_en;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic int min2(int a, int b);
        return (a < b) ? a : b;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                chk("missing_event_cycle", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (pulse_o || done) begin
                if (q.size() == 0 || q[0].cyc != cyc) begin
                    chk("unexpected_pulse", int'(pulse_o), 0);
                    chk("unexpected_done", int'(done), 0);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    chk(e.is_pulse ? "pulse_o" : "pulse_o_at_done", int'(pulse_o), int'(e.is_pulse));
                    chk(e.is_pulse ? "done_at_pulse" : "done", int'(done), int'(!e.is_pulse));
                    chk(e.is_pulse ? "sent_o_during_pulse" : "sent_o_at_done", int'(sent_o), e.sent);
                    if (!e.is_pulse) chk("paired_counter", pcnt, e.sent);
                end
            end
            if (pulse_o) pcnt++;
            chk("busy", int'(busy), int'(cyc >= bfrom && cyc < bto));
        end
    end

    // ab_off/rs_off: edges after acceptance at which abort/reset is sampled (0 = none).
    // ping: re-assert start one cycle into the train.
    task automatic run_train(input int n, input int g, input int ab_off,
                             input int rs_off, input bit ping);
        int e, d, a, r, fin, lim, j, cnt;
        bit cont;
        @(negedge clk);
        start = 1'b1; abort = 1'b0;
        num_i = CW'(n); gap_i = GW'(g);
        @(posedge clk); #1;
        e    = cyc;
        pcnt = 0;
        cont = CONT && (n == 0);
        if (cont)        d = INF;
        else if (n == 0) d = e;
        else             d = e + (n - 1) * (g + 1) + 1;
        a   = (ab_off > 0) ? e + ab_off : INF;
        r   = (rs_off > 0) ? e + rs_off : INF;
        fin = min2(d, a);
        lim = min2(fin, r);
        cnt = 0;
        for (j = 0; (cont || j < n) && (e + j * (g + 1) < lim) && j < 4000; j++) begin
            q.push_back('{cyc: e + j * (g + 1), is_pulse: 1'b1, sent: j});
            cnt++;
        end
        if (fin < r) q.push_back('{cyc: fin, is_pulse: 1'b0, sent: cnt});
        bfrom = e;
        bto   = lim;
        for (int c = 0; c < (lim - e) + 3 && c < 5000; c++) begin
            @(negedge clk);
            if (cyc == r) begin
                chk("rst_pulse_o", int'(pulse_o), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_sent_o", int'(sent_o), 0);
            end
            start = ping && (cyc == e);
            abort = (cyc == a - 1);
            rst_n = !(cyc == r - 1);
        end
        start = 1'b0; abort = 1'b0; rst_n = 1'b1;
    endtask

    initial begin
        int n, g, ab;
        mon_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_pulse_o", int'(pulse_o), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_sent_o", int'(sent_o), 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        run_train(3, 2, 0, 0, 1'b0);
        run_train(4, 0, 0, 0, 1'b1);
        run_train(5, 3, 6, 0, 1'b0);   // abort in gap after 2nd pulse
        run_train(5, 2, 4, 0, 1'b0);   // abort during a pulse counts it
        run_train(2, 1, 3, 0, 1'b0);   // abort with last pulse
        run_train(0, 2, 7, 0, 1'b0);
        run_train(10, 2, 0, 5, 1'b0);  // reset mid-gap
        run_train(4, 1, 0, 0, 1'b0);

        // start and abort together in IDLE must not launch a train
        @(negedge clk);
        start = 1'b1; abort = 1'b1; num_i = CW'(3); gap_i = GW'(1);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", int'(busy), 0);
        chk("start_abort_done", int'(done), 0);
        repeat (4) @(negedge clk);

        for (int t = 0; t < 20; t++) begin
            n  = $urandom_range(0, 6);
            g  = $urandom_range(0, 4);
            ab = ($urandom_range(0, 2) == 0 || (CONT && n == 0))
                 ? $urandom_range(1, (n + 1) * (g + 1) + 2) : 0;
            run_train(n, g, ab, 0, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
